seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit seven-segment display that shares one hex-to-segment decoder across all digits. It holds a displayed value plus a shadow value loaded through a valid/ready handshake, and commits the shadow only at frame boundaries so the display never tears. It also generates digit-select strobes with inter-digit blanking (anti-ghosting) and leading-zero suppression, and drives the board segment/digit pins directly.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8); digit 0 = least significant.
DIGIT_TICKS, 12000, clk cycles per digit slot (BLANK plus SHOW); must be > BLANK_TICKS.
BLANK_TICKS, 240, clk cycles at start of each slot with all digits off; must be >= 1.
COMMON_ANODE, 1, 1 = segments and dp active-low; 0 = active-high.
DIGIT_ACTIVE_LOW, 1, 1 = dig_sel active-low; 0 = active-high.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_data  in  4*NUM_DIGITS  nibble k = hex value of digit k
load_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
load_valid  in  1  new value offered
load_ready  out  1  high when the shadow register is free
lz_en  in  1  leading-zero suppression enable (sampled live)
disp_en  in  1  0 = all pins inactive; scanning continues
seg_out  out  7  segments {a,b,c,d,e,f,g}, registered
dp_out  out  1  decimal point, registered
dig_sel  out  NUM_DIGITS  one-hot (per polarity) digit enable, registered
frame_start  out  1  one-cycle pulse at the start of digit 0's BLANK phase

Behaviour:
- Reset is asynchronous on rst_n low and has the following effects:
  - FSM = BLANK, digit index = 0, tick counter = 0.
  - Active and shadow data/dp = 0, pending = 0, frame_start = 0.
  - seg_out = COMMON_ANODE ? 7'h7F : 7'h00; dp_out = COMMON_ANODE ? 1 : 0.
  - dig_sel = DIGIT_ACTIVE_LOW ? all ones : all zeros.
- Handshake:
  - load_ready = ~pending (combinational from the register), so it reads 1 during and after reset.
  - A transfer occurs on load_valid & load_ready at a clk edge. It captures load_data/load_dp into the shadow and sets pending.
  - load_valid while ready is low is ignored; the source must hold it.
- Tick counter: width $clog2(DIGIT_TICKS). Counts 0..DIGIT_TICKS-1 then wraps to 0 and advances the digit index. The index wraps from NUM_DIGITS-1 to 0.
- FSM, evaluated on counter value:
  - BLANK: counter < BLANK_TICKS. BLANK -> SHOW when the counter reaches BLANK_TICKS-1.
  - SHOW: the rest of the slot. SHOW -> BLANK at counter DIGIT_TICKS-1, with the index advancing.
- Frame commit: on the edge where the index wraps to 0 (or the first cycle after reset release):
  - if pending, active <= shadow and pending <= 0;
  - frame_start pulses on the following cycle, aligned with digit 0's first BLANK output cycle.
  - Commit and a new transfer cannot coincide because ready is low while pending.
- Output pipeline: pins are registered, so there is a 1-cycle latency from FSM/index state to pins.
  - BLANK, or disp_en = 0: all pins inactive (reset values).
  - SHOW: dig_sel asserts only the current index; seg_out = decode(active nibble[index]); dp_out = active dp[index], both with polarity applied.
- Leading-zero suppression: with lz_en = 1, digit k (k >= 1) is suppressed when nibbles NUM_DIGITS-1 down to k are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit shows segments off, but its dig_sel and dp are still driven normally.
- Reset mid-operation: pins go inactive immediately and any pending shadow is discarded. Scanning restarts at digit 0 BLANK.

Decomposition:
- Shared package seven_seg_pkg holds:
  - typedef scan_state_t {BLANK, SHOW};
  - SEG_OFF_CA = 7'h7F, SEG_OFF_CC = 7'h00;
  - function seg_polarity(logic [6:0] active_high, bit ca).
- One sub-module: instantiate the existing seven_seg_decoder (COMMON_ANODE passed through) on the muxed nibble.
  - Its output is registered here, not in the decoder.
  - No other sub-modules.

Test Plan:
1. Reset/idle (NUM_DIGITS=4, DIGIT_TICKS=8, BLANK_TICKS=2, CA, active-low digits): hold rst_n=0 -> seg_out=7'h7F, dp_out=1, dig_sel=4'hF, load_ready=1, frame_start=0.
2. Timing: release reset, data 0 -> each dig_sel bit low for exactly 6 consecutive cycles with 2 all-high cycles between digits; frame_start period = 32 cycles; order digit 0,1,2,3.
3. Tear-free load: load 0x1234, dp=4'b0010 mid-frame, during digit 2 -> load_ready falls next cycle; digits 2-3 keep showing '0'; after frame_start, digit 0 shows 7'b1001100 ('4') and digit 1 shows 7'b0000110 ('3') with dp_out=0; load_ready rises after the commit.
4. Back-pressure: hold load_valid with 0xAAAA while pending -> no capture until ready=1, then exactly one capture; the next frame shows 'A' (7'b0001000) on all digits.
5. Leading-zero suppression: 0x0050 with lz_en=1 -> digits 3 and 2 have segments 7'h7F while selected, digit 1 shows '5' (7'b0100100), digit 0 shows '0'; 0x0000 -> only digit 0 lit ('0'); with lz_en=0, all four digits show '0'.
6. Reset mid-SHOW with pending shadow: assert rst_n in digit 2 SHOW -> pins inactive the same instant; after release, active=0, load_ready=1, and the first selected digit is 0 after 2 BLANK cycles. With disp_en=0, pins stay inactive while frame_start keeps pulsing every 32 cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types, constants and polarity helper for the seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF_CA = 7'h7F;
    localparam logic [6:0] SEG_OFF_CC = 7'h00;

    // Converts an active-high segment pattern into the pin level for the display type.
    function automatic logic [6:0] seg_polarity(logic [6:0] active_high, bit ca);
        return ca ? ~active_high : active_high;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to seven-segment pattern {a,b,c,d,e,f,g}, polarity applied; purely combinational.
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] lit;

    always_comb begin
        lit = 7'h00;
        case (nibble)
            4'h0: lit = 7'h7E;
            4'h1: lit = 7'h30;
            4'h2: lit = 7'h6D;
            4'h3: lit = 7'h79;
            4'h4: lit = 7'h33;
            4'h5: lit = 7'h5B;
            4'h6: lit = 7'h5F;
            4'h7: lit = 7'h70;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h7B;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h1F;
            4'hC: lit = 7'h4E;
            4'hD: lit = 7'h3D;
            4'hE: lit = 7'h4F;
            4'hF: lit = 7'h47;
            default: lit = 7'h00;
        endcase
        seg = seg_polarity(lit, COMMON_ANODE);
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with tear-free shadow loading,
// inter-digit blanking, leading-zero suppression and registered pin outputs.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int DIGIT_TICKS      = 12000,
    parameter int BLANK_TICKS      = 240,
    parameter bit COMMON_ANODE     = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    input  logic [NUM_DIGITS-1:0]     load_dp,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic                      lz_en,
    input  logic                      disp_en,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_start
);

    localparam int CNT_W = $clog2(DIGIT_TICKS);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = COMMON_ANODE ? SEG_OFF_CA : SEG_OFF_CC;
    localparam logic                  DP_OFF     = COMMON_ANODE;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

    scan_state_t               state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic                      started;

    logic [4*NUM_DIGITS-1:0]   active_data;
    logic [NUM_DIGITS-1:0]     active_dp;
    logic [4*NUM_DIGITS-1:0]   shadow_data;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic                      pending;

    logic                      slot_end;
    logic                      commit;
    logic [3:0]                nibble;
    logic [6:0]                dec_seg;
    logic [NUM_DIGITS-1:0]     onehot;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic                      zero_run;

    assign load_ready = ~pending;
    assign slot_end   = (cnt == CNT_LAST);
    // The very first cycle out of reset counts as a frame boundary too.
    assign commit     = (slot_end && (idx == IDX_LAST)) || !started;
    assign nibble     = active_data[{idx, 2'b00} +: 4];
    assign onehot     = NUM_DIGITS'(1) << idx;

    // lz_mask[k] is set when every nibble from the top digit down to k is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (active_data[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    seven_seg_decoder #(
        .COMMON_ANODE(COMMON_ANODE)
    ) u_decoder (
        .nibble(nibble),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            started     <= 1'b0;
            frame_start <= 1'b0;
            seg_out     <= SEG_OFF;
            dp_out      <= DP_OFF;
            dig_sel     <= DIG_OFF;
        end else begin
            started <= 1'b1;
            cnt     <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            case (state)
                BLANK:   if (cnt == BLANK_LAST) state <= SHOW;
                SHOW:    if (slot_end) state <= BLANK;
                default: state <= BLANK;
            endcase

            // Pins lag the scan state by one cycle, so the pulse marks digit 0's first blank output.
            frame_start <= (cnt == '0) && (idx == '0);

            if (disp_en && (state == SHOW)) begin
                seg_out <= (lz_en && lz_mask[idx]) ? SEG_OFF : dec_seg;
                dp_out  <= COMMON_ANODE ? ~active_dp[idx] : active_dp[idx];
                dig_sel <= DIGIT_ACTIVE_LOW ? ~onehot : onehot;
            end else begin
                seg_out <= SEG_OFF;
                dp_out  <= DP_OFF;
                dig_sel <= DIG_OFF;
            end
        end
    end

    // Shadow handshake and frame-boundary commit; the two never coincide since ready is low while pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_data <= '0;
            active_dp   <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
        end else begin
            if (commit && pending) begin
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
                pending     <= 1'b0;
            end else if (load_valid && !pending) begin
                shadow_data <= load_data;
                shadow_dp   <= load_dp;
                pending     <= 1'b1;
            end
        end
    end

endmodule
